// File: rtl/vdec_hs_crc_pkg.sv
// ============================================================================
// Module  : vdec_hs_crc_pkg
// Brief   : Shared constants, types and helpers for the parallel HS CRC checker.
// Options : VDEC_HS_CRC_UE_MASK_EN (used by vdec_hs_crc_check_par)
// Rev     : 1.0  initial parallel release
// ============================================================================
`default_nettype none

package vdec_hs_crc_pkg;

   // Default CRC-16/CCITT generator (x^16 term implicit) and zero preset.
   localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT_ZERO    = 16'h0000;

   // Group counter is wide enough for INFO_W up to 255 at one bit per clock.
   localparam int GRP_CNT_W = 8;
   // Lane count must represent 0..8 (BPC upper bound).
   localparam int LANE_W    = 4;

   typedef logic [GRP_CNT_W-1:0] grp_cnt_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } crc_state_t;

   // Number of BPC-wide groups needed to cover len bits: ceil(len/bpc).
   function automatic grp_cnt_t calc_groups(input int len, input int bpc);
      return grp_cnt_t'((len + bpc - 1) / bpc);
   endfunction

endpackage

`default_nettype wire

// File: rtl/vdec_hs_crc_step.sv
// ============================================================================
// Module  : vdec_hs_crc_step
// Brief   : Combinational BPC-bit LFSR CRC step. Lanes at or above 'lanes'
//           pass the CRC through unchanged so a short final group works.
// Rev     : 1.0  initial parallel release
// ============================================================================
`default_nettype none

module vdec_hs_crc_step
   import vdec_hs_crc_pkg::*;
#(
   parameter int               CRC_W = 16,
   parameter logic [CRC_W-1:0] POLY  = CRC16_CCITT_POLY,
   parameter int               BPC   = 1
) (
   input  logic [CRC_W-1:0]  crc_reg,
   input  logic [BPC-1:0]    data,
   input  logic [LANE_W-1:0] lanes,
   output logic [CRC_W-1:0]  crc_next
);

   // chain[i] is the CRC after the first i lanes; chain[0] is the input.
   logic [BPC:0][CRC_W-1:0] chain;

   assign chain[0] = crc_reg;

   for (genvar i = 0; i < BPC; i++) begin : g_lane
      logic             fb;
      logic [CRC_W-1:0] upd;

      assign fb          = chain[i][CRC_W-1] ^ data[i];
      assign upd         = (chain[i] << 1) ^ (fb ? POLY : {CRC_W{1'b0}});
      assign chain[i+1]  = (LANE_W'(i) < lanes) ? upd : chain[i];
   end

   assign crc_next = chain[BPC];

endmodule

`default_nettype wire

// File: rtl/vdec_hs_crc_check_par.sv
// ============================================================================
// Module  : vdec_hs_crc_check_par
// Brief   : Parametrised HS CRC checker. Runs an LFSR CRC over a variable
//           length info field, BPC bits per clock (LSB first), and compares
//           it with the received CRC.
// Options : VDEC_HS_CRC_UE_MASK_EN adds ue_mask; result is XORed with it.
// Rev     : 1.0  initial parallel release
// ============================================================================
`default_nettype none

module vdec_hs_crc_check_par
   import vdec_hs_crc_pkg::*;
#(
   parameter int               INFO_W   = 21,
   parameter int               CRC_W    = 16,
   parameter logic [CRC_W-1:0] POLY     = CRC16_CCITT_POLY,
   parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_ZERO,
   parameter int               BPC      = 1,
   parameter int               LEN_W    = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  info_len,
   input  logic [INFO_W-1:0] info_bits,
   input  logic [CRC_W-1:0]  crc_bits,
`ifdef VDEC_HS_CRC_UE_MASK_EN
   input  logic [CRC_W-1:0]  ue_mask,
`endif
   output logic              busy,
   output logic              done,
   output logic              crc_match,
   output logic [CRC_W-1:0]  crc_calc
);

   crc_state_t        state;
   crc_state_t        state_nxt;
   logic              last_grp;

   logic [INFO_W-1:0] info_cache;
   logic [CRC_W-1:0]  crc_cache;
   logic [CRC_W-1:0]  crc_reg;
   grp_cnt_t          grp_cnt;
   logic [LEN_W-1:0]  bits_left;

   logic [LEN_W-1:0]  len_clamped;
   grp_cnt_t          groups;
   logic [LANE_W-1:0] lanes;
   logic [CRC_W-1:0]  crc_next;
   logic [CRC_W-1:0]  mask;
   logic [CRC_W-1:0]  crc_final;

   // Lengths beyond the info field are treated as a full-width field.
   assign len_clamped = (info_len > LEN_W'(INFO_W)) ? LEN_W'(INFO_W) : info_len;
   assign groups      = calc_groups(int'(len_clamped), BPC);

   // Only the final group can be partial; it uses the bits still pending.
   assign lanes = (int'(bits_left) >= BPC) ? LANE_W'(BPC) : LANE_W'(bits_left);

   vdec_hs_crc_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .BPC   (BPC)
   ) u_step (
      .crc_reg  (crc_reg),
      .data     (info_cache[BPC-1:0]),
      .lanes    (lanes),
      .crc_next (crc_next)
   );

`ifdef VDEC_HS_CRC_UE_MASK_EN
   logic [CRC_W-1:0] mask_cache;

   // Capture the UE identity mask together with the rest of the job.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_cache <= '0;
      end else if (start) begin
         mask_cache <= ue_mask;
      end
   end

   assign mask = mask_cache;
`else
   assign mask = '0;
`endif

   assign crc_final = crc_next ^ mask;

   // State register: IDLE until a start, RUN while groups remain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a start always (re)enters RUN, even on the final group.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            if (start)         state_nxt = ST_RUN;
            else if (last_grp) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded outputs; a zero-length job still takes one RUN cycle.
   always_comb begin
      busy     = (state == ST_RUN);
      last_grp = (state == ST_RUN) && (grp_cnt <= grp_cnt_t'(1));
   end

   // Datapath: job load on start, one group per RUN cycle, result on last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         info_cache <= '0;
         crc_cache  <= '0;
         crc_reg    <= '0;
         grp_cnt    <= '0;
         bits_left  <= '0;
         done       <= 1'b0;
         crc_match  <= 1'b0;
         crc_calc   <= '0;
      end else begin
         done <= 1'b0;

         // The in-flight job still reports if its last group meets a start.
         if (last_grp) begin
            done      <= 1'b1;
            crc_calc  <= crc_final;
            crc_match <= (crc_final == crc_cache);
         end else if (start) begin
            crc_calc  <= '0;
            crc_match <= 1'b0;
         end

         if (start) begin
            info_cache <= info_bits;
            crc_cache  <= crc_bits;
            crc_reg    <= CRC_INIT;
            grp_cnt    <= groups;
            bits_left  <= len_clamped;
         end else if (state == ST_RUN) begin
            crc_reg    <= crc_next;
            info_cache <= info_cache >> BPC;
            bits_left  <= bits_left - LEN_W'(lanes);
            if (grp_cnt != '0) begin
               grp_cnt <= grp_cnt - grp_cnt_t'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire
